// File: rtl/shr_seq_32.sv
// Multi-cycle 32-bit right shifter: logical, arithmetic and rotate, one bit per clock.
// z_high collects the bits shifted out of the operand, left-justified.
module shr_seq_32 (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] shifts,
  output logic [31:0] z_low,
  output logic [31:0] z_high,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SHRA = 2'b01;
  localparam logic [1:0] OP_ROR  = 2'b10;

  state_t      state_r;
  state_t      state_nx_s;
  logic [4:0]  cnt_r;
  logic [4:0]  cnt_nx_s;
  logic [1:0]  op_r;
  logic [1:0]  op_nx_s;
  logic [31:0] z_low_r;
  logic [31:0] z_low_nx_s;
  logic [31:0] z_high_r;
  logic [31:0] z_high_nx_s;
  logic        busy_r;
  logic        done_r;

  // Only the low five bits of the count matter; a count of 32 wraps to 0.
  logic unused_shifts_s;
  assign unused_shifts_s = ^shifts[31:5];

  // Next-state and datapath decode.
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r;
    op_nx_s     = op_r;
    z_low_nx_s  = z_low_r;
    z_high_nx_s = z_high_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          op_nx_s     = op;
          z_low_nx_s  = in1;
          z_high_nx_s = 32'd0;
          cnt_nx_s    = shifts[4:0];
          if (shifts[4:0] == 5'd0) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_SHIFT;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        cnt_nx_s = cnt_r - 5'd1;
        case (op_r)
          OP_SHRA: begin
            z_low_nx_s  = {z_low_r[31], z_low_r[31:1]};
            z_high_nx_s = {z_low_r[0], z_high_r[31:1]};
          end
          OP_ROR: begin
            z_low_nx_s  = {z_low_r[0], z_low_r[31:1]};
            z_high_nx_s = 32'd0;
          end
          // SHR, and the reserved encoding behaves the same way
          default: begin
            z_low_nx_s  = {1'b0, z_low_r[31:1]};
            z_high_nx_s = {z_low_r[0], z_high_r[31:1]};
          end
        endcase
        if (cnt_r == 5'd1) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, operand and result registers; busy/done are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 5'd0;
      op_r     <= 2'b00;
      z_low_r  <= 32'd0;
      z_high_r <= 32'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      cnt_r    <= cnt_nx_s;
      op_r     <= op_nx_s;
      z_low_r  <= z_low_nx_s;
      z_high_r <= z_high_nx_s;
      busy_r   <= (state_nx_s != ST_IDLE);
      done_r   <= (state_nx_s == ST_DONE);
    end
  end

  assign z_low  = z_low_r;
  assign z_high = z_high_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_shr_seq_32.sv
// Self-checking bench for shr_seq_32: directed vectors, random operations against a
// 64-bit arithmetic reference model, back-to-back starts and asynchronous reset abort.
module tb_shr_seq_32;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] in1 = 32'd0;
  logic [31:0] shifts = 32'd0;
  logic [31:0] z_low;
  logic [31:0] z_high;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  shr_seq_32 dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .op     (op),
    .in1    (in1),
    .shifts (shifts),
    .z_low  (z_low),
    .z_high (z_high),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Reference: place operand in the upper half of a 64-bit word and shift it as a whole.
  function automatic logic [63:0] ref_shift(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] sh);
    int unsigned n;
    logic [63:0] w;
    logic [63:0] dbl;
    n = sh % 32;
    w = {a, 32'd0};
    case (o)
      2'b01: w = $signed(w) >>> n;
      2'b10: begin
        dbl = {a, a} >> n;
        w   = {dbl[31:0], 32'd0};
      end
      default: w = w >> n;
    endcase
    return w;
  endfunction

  task automatic do_shift(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] sh, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi);
    int n;
    n = int'(sh[4:0]);
    @(negedge clk);
    start = 1'b1; op = o; in1 = a; shifts = sh;
    @(posedge clk);
    #1;
    start = 1'($urandom_range(0, 1)); op = 2'($urandom); in1 = $urandom; shifts = $urandom;
    for (int i = 0; i <= n + 1; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== (i == n)) begin
        n_fail++;
        $display("FAIL %s done at cycle %0d: got %b expected %b", name, i, done, (i == n));
      end
      n_checks++;
      if (busy !== (i <= n)) begin
        n_fail++;
        $display("FAIL %s busy at cycle %0d: got %b expected %b", name, i, busy, (i <= n));
      end
      if (i >= n) begin
        n_checks++;
        if (z_low !== exp_lo || z_high !== exp_hi) begin
          n_fail++;
          $display("FAIL %s result at cycle %0d: got %h_%h expected %h_%h",
                   name, i, z_low, z_high, exp_lo, exp_hi);
        end
      end
      if (i <= n) begin
        start = 1'($urandom_range(0, 1)); op = 2'($urandom); in1 = $urandom; shifts = $urandom;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    #2 clr = 1'b0;
    #4;
    n_checks++;
    if (z_low !== 32'd0 || z_high !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %h %h %b %b expected 0 0 0 0", z_low, z_high, busy, done);
    end
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_start: got busy %b done %b expected 0 0", busy, done);
    end
    start = 1'b0;
    clr = 1'b1;
  endtask

  task automatic test_directed();
    do_shift("shr_7",      2'b00, 32'h00015555, 32'd7,  32'h000002AA, 32'hAA000000);
    do_shift("shra_neg",   2'b01, 32'hAAA00000, 32'd7,  32'hFF554000, 32'h00000000);
    do_shift("shra_pos",   2'b01, 32'h0000FFFF, 32'd7,  32'h000001FF, 32'hFE000000);
    do_shift("ror_7",      2'b10, 32'h0000FFFF, 32'd7,  32'hFE0001FF, 32'h00000000);
    do_shift("rsvd_7",     2'b11, 32'h00015555, 32'd7,  32'h000002AA, 32'hAA000000);
    do_shift("count_32",   2'b00, 32'h00000001, 32'd32, 32'h00000001, 32'h00000000);
    do_shift("shr_31",     2'b00, 32'hFFFFFFFF, 32'd31, 32'h00000001, 32'hFFFFFFFE);
    do_shift("ror_hi_ign", 2'b10, 32'h80000001, 32'hFFFFFFE1, 32'hC0000000, 32'h00000000);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] sh;
    logic [63:0] r;
    for (int t = 0; t < 24; t++) begin
      o  = 2'($urandom_range(0, 3));
      a  = $urandom;
      sh = $urandom;
      r  = ref_shift(o, a, sh);
      do_shift("random", o, a, sh, r[63:32], r[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  bo [4];
    logic [31:0] ba [4];
    logic [31:0] bs [4];
    logic [63:0] r;
    int k;
    @(negedge clk);
    bo[0] = 2'($urandom); ba[0] = $urandom; bs[0] = ($urandom & 32'hFFFFFFE0) | 32'd3;
    start = 1'b1; op = bo[0]; in1 = ba[0]; shifts = bs[0];
    for (int j = 0; j <= 18; j++) begin
      @(negedge clk);
      n_checks++;
      if (done !== ((j % 5) == 3)) begin
        n_fail++;
        $display("FAIL b2b done at cycle %0d: got %b expected %b", j, done, ((j % 5) == 3));
      end
      n_checks++;
      if (busy !== ((j % 5) != 4)) begin
        n_fail++;
        $display("FAIL b2b busy at cycle %0d: got %b expected %b", j, busy, ((j % 5) != 4));
      end
      if ((j % 5) == 3) begin
        k = j / 5;
        r = ref_shift(bo[k], ba[k], bs[k]);
        n_checks++;
        if (z_low !== r[63:32] || z_high !== r[31:0]) begin
          n_fail++;
          $display("FAIL b2b result %0d: got %h_%h expected %h_%h", k, z_low, z_high,
                   r[63:32], r[31:0]);
        end
      end
      if (j == 18) begin
        start = 1'b0;
      end else if ((j % 5) == 4) begin
        k = (j + 1) / 5;
        bo[k] = 2'($urandom); ba[k] = $urandom; bs[k] = ($urandom & 32'hFFFFFFE0) | 32'd3;
        op = bo[k]; in1 = ba[k]; shifts = bs[k];
      end else begin
        op = 2'($urandom); in1 = $urandom; shifts = $urandom;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    start = 1'b1; op = 2'b00; in1 = 32'h12345678; shifts = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #3 clr = 1'b0;
    #1;
    n_checks++;
    if (z_low !== 32'd0 || z_high !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_clear: got %h %h %b %b expected 0 0 0 0", z_low, z_high, busy, done);
    end
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    clr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet cycle %0d: got done %b busy %b expected 0 0", i, done, busy);
      end
    end
    do_shift("abort_recover", 2'b00, 32'h80000000, 32'd31, 32'h00000001, 32'h00000000);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shr_seq_32.md
SHR_SEQ_32 -- requirements
Module: shr_seq_32

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port clr, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port start, input, 1 bit: request a shift; sampled only in IDLE.
REQ-004 The block SHALL have the port op, input, 2 bits: 00 logical right (SHR), 01 arithmetic right (SHRA), 10 rotate right (ROR), 11 reserved (executes as SHR).
REQ-005 The block SHALL have the port in1, input, 32 bits: operand.
REQ-006 The block SHALL have the port shifts, input, 32 bits: shift count; only bits [4:0] are used, bits [31:5] are ignored.
REQ-007 The block SHALL have the port z_low, output, 32 bits: result word.
REQ-008 The block SHALL have the port z_high, output, 32 bits: bits shifted out of in1, left-justified; zero for ROR.
REQ-009 The block SHALL have the port busy, output, 1 bit: high in SHIFT and DONE states.
REQ-010 The block SHALL have the port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL latch op, load z_low<=in1 and z_high<=0, load the 5-bit counter with shifts[4:0], and go to DONE if the count is 0, else to SHIFT.
REQ-013 In IDLE with start=0, the block SHALL hold all registers unchanged.
REQ-014 In SHIFT, each rising edge SHALL perform a one-bit right step on the 64-bit value {z_low,z_high} and decrement the counter.
REQ-015 For a SHR step, the block SHALL fill z_low[31] with 0, move z_low[0] into z_high[31], and shift z_high right by 1.
REQ-016 For a SHRA step, the block SHALL fill z_low[31] with the current z_low[31]; z_high SHALL behave as for SHR.
REQ-017 For a ROR step, the block SHALL move z_low[0] into z_low[31] and keep z_high at 0.
REQ-018 On the edge where the counter goes from 1 to 0, the block SHALL go to DONE.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-020 The done output SHALL be decoded from state (Moore) and be high only in DONE.
REQ-021 Latency: for count n, done SHALL be high during the cycle following rising edge E0+n, where E0 is the start-sampling edge; total n+1 cycles, with n=0 giving 1 cycle.
REQ-022 start SHALL be ignored while busy=1; operands are captured at E0 only, and later changes to in1, shifts or op SHALL have no effect.
REQ-023 z_low and z_high SHALL hold the final result after DONE until the next accepted start.
REQ-024 start asserted during the DONE cycle SHALL be ignored; it is accepted only if it is still high in IDLE.
REQ-025 The final result SHALL equal the combinational right shift, arithmetic right shift or rotate of in1 by shifts[4:0]; shifts=32 therefore behaves as 0.

Reset
REQ-026 clr=0 SHALL asynchronously force state=IDLE, counter=0, z_low=0, z_high=0, busy=0 and done=0, regardless of clk.
REQ-027 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; after release the block SHALL accept a new start normally.
REQ-028 Reset release SHALL take effect synchronously at the next edge only in the sense that no start is sampled while clr=0.

Verification
REQ-029 The bench SHALL check: SHR, in1=0x00015555, shifts=7, start pulse -> done in cycle after E0+7; z_low=0x000002AA, z_high=0xAA000000.
REQ-030 The bench SHALL check: SHRA, in1=0xAAA00000, shifts=7 -> z_low=0xFF554000, z_high=0x00000000; and in1=0x0000FFFF, shifts=7, SHRA -> z_low=0x000001FF, z_high=0xFE000000.
REQ-031 The bench SHALL check: ROR, in1=0x0000FFFF, shifts=7 -> z_low=0xFE0001FF, z_high=0; and op=11 gives the SHR result.
REQ-032 The bench SHALL check: in1=0x00000001, shifts=32 (count 0) -> done in cycle after E0; z_low=0x00000001, z_high=0, busy high for exactly 1 cycle.
REQ-033 The bench SHALL check: start held high continuously with shifts=3 -> operations back-to-back with done every 5 cycles (IDLE, 3 SHIFT, DONE), each result matching the operands sampled at its own E0.
REQ-034 The bench SHALL check: clr pulsed low after 2 of 7 shift steps, asynchronously between edges -> outputs 0 immediately, no done pulse; next start of SHR 0x80000000 by 31 -> z_low=0x00000001, z_high=0.
